// File: rtl/histo_frame_seq.sv
// Histogram frame sequencer: aligns accumulation to whole frames, checks frame
// geometry, and requests a histogram dump every N frames with an ack timeout.
module histo_frame_seq #(
    parameter int CNT_W = 16,
    parameter int TMO_W = 24
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             enable_i,
    input  logic [7:0]       frames_per_dump_i,
    input  logic [CNT_W-1:0] exp_width_i,
    input  logic [CNT_W-1:0] exp_height_i,
    input  logic             cam_fv_i,
    input  logic             cam_lv_i,
    input  logic             dump_ack_i,
    input  logic             err_clr_i,
    output logic             acc_en_o,
    output logic             acc_clr_o,
    output logic             dump_req_o,
    output logic [15:0]      frame_id_o,
    output logic             frame_err_o,
    output logic [3:0]       err_flags_o,
    output logic [2:0]       state_o,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_ARM   = 3'd2,
        S_ACCUM = 3'd3,
        S_DUMP  = 3'd4
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state, w_nxt;
    logic             r_fv_d, r_lv_d;
    logic [CNT_W-1:0] r_pix, r_line;
    logic             r_line_bad;
    logic [7:0]       r_group_len, r_fig;
    logic [TMO_W-1:0] r_tmo;
    logic             r_acc_en, r_acc_clr, r_frame_err;
    logic [15:0]      r_frame_id;
    logic [3:0]       r_err;

    logic             w_fv_rise, w_fv_fall, w_lv_fall;
    logic             w_in_accum, w_pix_bad, w_h_bad, w_grp_last, w_tmo_hit;
    logic [CNT_W-1:0] w_pix_inc, w_line_inc, w_line_fin;
    logic             w_clr, w_latch, w_frame_done, w_timeout;
    logic [3:0]       w_err_set;

    assign w_fv_rise  = cam_fv_i & ~r_fv_d;
    assign w_fv_fall  = ~cam_fv_i & r_fv_d;
    assign w_lv_fall  = ~cam_lv_i & r_lv_d;
    assign w_in_accum = (r_state == S_ACCUM) && enable_i;
    assign w_pix_inc  = (r_pix == '1) ? r_pix : r_pix + CNT_ONE;
    assign w_line_inc = (r_line == '1) ? r_line : r_line + CNT_ONE;
    // A line ending in the same cycle as the frame still counts toward height.
    assign w_line_fin = w_lv_fall ? w_line_inc : r_line;
    assign w_pix_bad  = w_lv_fall && (r_pix != exp_width_i);
    assign w_h_bad    = (w_line_fin != exp_height_i);
    assign w_grp_last = ({1'b0, r_fig} + 9'd1) == {1'b0, r_group_len};
    assign w_tmo_hit  = (r_tmo == TMO_LAST);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= S_IDLE;
        else         r_state <= w_nxt;
    end

    always_comb begin
        w_nxt        = r_state;
        w_clr        = 1'b0;
        w_latch      = 1'b0;
        w_frame_done = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: if (enable_i) w_nxt = S_SYNC;
            S_SYNC: begin
                if (!enable_i) w_nxt = S_IDLE;
                else if (!cam_fv_i) begin
                    w_nxt   = S_ARM;
                    w_clr   = 1'b1;
                    w_latch = 1'b1;
                end
            end
            S_ARM: begin
                if (!enable_i)     w_nxt = S_IDLE;
                else if (w_fv_rise) w_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                if (!enable_i) w_nxt = S_IDLE;
                else if (w_fv_fall) begin
                    w_frame_done = 1'b1;
                    w_nxt        = w_grp_last ? S_DUMP : S_ARM;
                end
            end
            S_DUMP: begin
                if (dump_ack_i) begin
                    w_nxt   = enable_i ? S_ARM : S_IDLE;
                    w_clr   = enable_i;
                    w_latch = enable_i;
                end else if (w_tmo_hit) begin
                    w_timeout = 1'b1;
                    w_nxt     = enable_i ? S_SYNC : S_IDLE;
                    w_clr     = enable_i;
                end
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    assign w_err_set = {(r_state == S_DUMP) && w_fv_rise,
                        w_timeout,
                        w_frame_done && w_h_bad,
                        w_in_accum && w_pix_bad};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_fv_d      <= 1'b0;
            r_lv_d      <= 1'b0;
            r_pix       <= '0;
            r_line      <= '0;
            r_line_bad  <= 1'b0;
            r_group_len <= 8'd0;
            r_fig       <= 8'd0;
            r_tmo       <= '0;
            r_acc_en    <= 1'b0;
            r_acc_clr   <= 1'b0;
            r_frame_err <= 1'b0;
            r_frame_id  <= 16'd0;
            r_err       <= 4'd0;
        end else begin
            r_fv_d      <= cam_fv_i;
            r_lv_d      <= cam_lv_i;
            r_acc_clr   <= w_clr;
            r_frame_err <= 1'b0;
            r_acc_en    <= 1'b0;
            r_tmo       <= (r_state == S_DUMP) ? r_tmo + TMO_ONE : '0;
            // Set beats clear when both land in the same cycle.
            r_err       <= (err_clr_i ? 4'd0 : r_err) | w_err_set;
            if (w_latch) begin
                r_group_len <= (frames_per_dump_i == 8'd0) ? 8'd1 : frames_per_dump_i;
                r_fig       <= 8'd0;
            end
            if (r_state == S_ARM) begin
                r_line     <= '0;
                r_line_bad <= 1'b0;
                // A line may start in the same cycle as the frame.
                if (enable_i && w_fv_rise && cam_lv_i) begin
                    r_pix    <= CNT_ONE;
                    r_acc_en <= 1'b1;
                end else begin
                    r_pix <= '0;
                end
            end
            if (w_in_accum) begin
                r_acc_en <= cam_fv_i & cam_lv_i;
                if (cam_lv_i) r_pix <= w_pix_inc;
                if (w_lv_fall) begin
                    r_pix  <= '0;
                    r_line <= w_line_inc;
                    if (w_pix_bad) r_line_bad <= 1'b1;
                end
                if (w_frame_done) begin
                    r_frame_err <= r_line_bad | w_pix_bad | w_h_bad;
                    r_frame_id  <= r_frame_id + 16'd1;
                    r_fig       <= r_fig + 8'd1;
                end
            end
        end
    end

    assign acc_en_o    = r_acc_en;
    assign acc_clr_o   = r_acc_clr;
    assign dump_req_o  = (r_state == S_DUMP);
    assign frame_id_o  = r_frame_id;
    assign frame_err_o = r_frame_err;
    assign err_flags_o = r_err;
    assign state_o     = r_state;
    assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_histo_frame_seq.sv
// Directed bench for histo_frame_seq: frame groups, geometry errors, dump
// ack/timeout, enable alignment and asynchronous reset.
module tb_histo_frame_seq;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        enable_i;
    logic [7:0]  frames_per_dump_i;
    logic [15:0] exp_width_i, exp_height_i;
    logic        cam_fv_i, cam_lv_i, dump_ack_i, err_clr_i;
    logic        acc_en_o, acc_clr_o, dump_req_o, frame_err_o, busy_o;
    logic [15:0] frame_id_o;
    logic [3:0]  err_flags_o;
    logic [2:0]  state_o;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc, n_clr, n_ferr;

    histo_frame_seq #(.CNT_W(16), .TMO_W(4)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .enable_i(enable_i),
        .frames_per_dump_i(frames_per_dump_i),
        .exp_width_i(exp_width_i), .exp_height_i(exp_height_i),
        .cam_fv_i(cam_fv_i), .cam_lv_i(cam_lv_i),
        .dump_ack_i(dump_ack_i), .err_clr_i(err_clr_i),
        .acc_en_o(acc_en_o), .acc_clr_o(acc_clr_o), .dump_req_o(dump_req_o),
        .frame_id_o(frame_id_o), .frame_err_o(frame_err_o),
        .err_flags_o(err_flags_o), .state_o(state_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (acc_en_o)    n_acc++;
        if (acc_clr_o)   n_clr++;
        if (frame_err_o) n_ferr++;
    endtask

    // nl lines of width w; line bad_i uses width bad_w; sim: lv and fv fall together
    task automatic send_frame(input int nl, input int w, input int bad_i, input int bad_w, input bit sim);
        cam_fv_i = 1'b1;
        tick();
        for (int i = 0; i < nl; i++) begin
            cam_lv_i = 1'b1;
            repeat ((i == bad_i) ? bad_w : w) tick();
            cam_lv_i = 1'b0;
            if (sim && i == nl - 1) cam_fv_i = 1'b0;
            tick();
        end
        if (!sim) begin
            cam_fv_i = 1'b0;
            tick();
        end
    endtask

    task automatic ack();
        dump_ack_i = 1'b1;
        tick();
        dump_ack_i = 1'b0;
    endtask

    initial begin
        int cnt;
        rstn_i = 1'b0; enable_i = 1'b0; frames_per_dump_i = 8'd1;
        exp_width_i = 16'd4; exp_height_i = 16'd3;
        cam_fv_i = 1'b0; cam_lv_i = 1'b0; dump_ack_i = 1'b0; err_clr_i = 1'b0;
        n_acc = 0; n_clr = 0; n_ferr = 0;
        #23;
        chk("rst_state", state_o, 0);
        chk("rst_ctl", {acc_en_o, acc_clr_o, dump_req_o, frame_err_o, busy_o}, 0);
        chk("rst_fid", frame_id_o, 0);
        chk("rst_err", err_flags_o, 0);
        rstn_i = 1'b1;
        tick();

        // single-frame group
        enable_i = 1'b1;
        tick();
        chk("sync", state_o, 1);
        tick();
        chk("arm", state_o, 2);
        chk("arm_clr", acc_clr_o, 1);
        n_acc = 0; n_ferr = 0;
        send_frame(3, 4, -1, 0, 0);
        chk("f1_state", state_o, 4);
        chk("f1_req", dump_req_o, 1);
        chk("f1_fid", frame_id_o, 1);
        chk("f1_acc", n_acc, 12);
        chk("f1_ferr", n_ferr, 0);
        frames_per_dump_i = 8'd3;
        n_clr = 0;
        ack();
        chk("ack_req", dump_req_o, 0);
        chk("ack_clr", acc_clr_o, 1);
        chk("ack_state", state_o, 2);
        tick();
        chk("ack_clr_pulse", n_clr, 1);

        // geometry errors over a 3-frame group, back-to-back frames
        send_frame(3, 4, -1, 0, 0);
        chk("g1_state", {state_o, frame_id_o}, {3'd2, 16'd2});
        send_frame(3, 4, 1, 5, 0);
        chk("g2_state", {state_o, frame_id_o}, {3'd2, 16'd3});
        chk("g2_ferr", n_ferr, 1);
        chk("g2_err", err_flags_o, 4'b0001);
        send_frame(2, 4, -1, 0, 0);
        chk("g3_state", {state_o, frame_id_o}, {3'd4, 16'd4});
        chk("g3_ferr", n_ferr, 2);
        chk("g3_err", err_flags_o, 4'b0011);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("errclr", err_flags_o, 4'b0000);
        chk("g3_ferr_once", n_ferr, 2);
        frames_per_dump_i = 8'd0;
        ack();

        // frames_per_dump 0, simultaneous lv/fv fall on the last line
        send_frame(3, 4, -1, 0, 1);
        chk("z1_state", {state_o, frame_id_o}, {3'd4, 16'd5});
        chk("z1_err", {err_flags_o, 4'(n_ferr)}, {4'b0000, 4'd2});
        ack();
        send_frame(3, 4, -1, 0, 0);
        chk("z2_state", {state_o, frame_id_o}, {3'd4, 16'd6});

        // dump stall with a skipped frame
        n_clr = 0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 3) cam_fv_i = 1'b1;
            tick();
            cnt++;
            if (!dump_req_o) break;
        end
        chk("tmo_cycles", cnt, 15);
        chk("tmo_err", err_flags_o, 4'b1100);
        chk("tmo_state", state_o, 1);
        chk("tmo_clr", {acc_clr_o, 4'(n_clr)}, {1'b1, 4'd1});
        tick();
        chk("sync_hold", state_o, 1);
        cam_fv_i = 1'b0;
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("sync_arm", {state_o, acc_clr_o, err_flags_o}, {3'd2, 1'b1, 4'b0000});

        // enable mid-stream
        enable_i = 1'b0;
        tick();
        chk("dis_idle", {state_o, busy_o}, {3'd0, 1'b0});
        frames_per_dump_i = 8'd2;
        cam_fv_i = 1'b1;
        tick();
        enable_i = 1'b1;
        n_acc = 0;
        tick();
        cam_lv_i = 1'b1;
        tick(); tick();
        cam_lv_i = 1'b0;
        tick();
        chk("en_sync", state_o, 1);
        chk("en_noacc", n_acc, 0);
        cam_fv_i = 1'b0;
        tick();
        chk("en_arm", state_o, 2);
        send_frame(3, 4, -1, 0, 0);
        chk("en_f1", {state_o, frame_id_o, 8'(n_acc)}, {3'd2, 16'd7, 8'd12});
        send_frame(3, 4, -1, 0, 0);
        chk("en_f2", {state_o, frame_id_o, 8'(n_acc)}, {3'd4, 16'd8, 8'd24});
        enable_i = 1'b0;
        ack();
        chk("ack_idle", {state_o, acc_clr_o, dump_req_o}, {3'd0, 1'b0, 1'b0});

        // asynchronous reset mid-line
        enable_i = 1'b1;
        tick(); tick();
        cam_fv_i = 1'b1;
        tick();
        cam_lv_i = 1'b1;
        tick(); tick();
        chk("pre_rst", {acc_en_o, busy_o, state_o}, {1'b1, 1'b1, 3'd3});
        #2;
        rstn_i = 1'b0;
        #1;
        chk("arst_ctl", {acc_en_o, busy_o, state_o}, {1'b0, 1'b0, 3'd0});
        chk("arst_fid", frame_id_o, 0);
        cam_fv_i = 1'b0; cam_lv_i = 1'b0;
        #10;
        rstn_i = 1'b1;
        tick();
        chk("post_rst", state_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
